// File: rtl/median_pkg.sv
// Shared encodings for the partition_select block: FSM states, partition select
// codes and a helper that says which selections have a buffer to drain.
package median_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FILL   = 3'd1,
    ST_DECIDE = 3'd2,
    ST_RESULT = 3'd3,
    ST_DRAIN  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    SEL_LOWER  = 2'b00,
    SEL_EQUAL  = 2'b01,
    SEL_LARGER = 2'b10,
    SEL_EMPTY  = 2'b11
  } sel_t;

  // Only the lower and larger partitions are buffered; equal and empty carry no data.
  function automatic logic sel_drains(input sel_t s);
    return (s == SEL_LOWER) || (s == SEL_LARGER);
  endfunction

endpackage

// File: rtl/partition_fsm.sv
// Control FSM for partition_select: state register, next-state logic and
// state-decoded strobes. Strobes are forced low while rst is asserted.
module partition_fsm
  import median_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic cfg_valid,
  input  logic cfg_size_zero,
  input  logic fill_last,
  input  logic res_ready,
  input  logic res_drain,
  input  logic drain_last,
  output logic cfg_ready,
  output logic fill_en,
  output logic decide_en,
  output logic res_valid,
  output logic drain_en
);

  state_t state_q;
  state_t state_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (cfg_valid) state_d = cfg_size_zero ? ST_DECIDE : ST_FILL;
      ST_FILL:   if (fill_last) state_d = ST_DECIDE;
      ST_DECIDE: state_d = ST_RESULT;
      ST_RESULT: if (res_ready) state_d = res_drain ? ST_DRAIN : ST_IDLE;
      ST_DRAIN:  if (drain_last) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Gating with rst keeps a pass from reading or transferring during the reset cycle.
  always_comb begin
    cfg_ready = ~rst & (state_q == ST_IDLE);
    fill_en   = ~rst & (state_q == ST_FILL);
    decide_en = ~rst & (state_q == ST_DECIDE);
    res_valid = ~rst & (state_q == ST_RESULT);
    drain_en  = ~rst & (state_q == ST_DRAIN);
  end

endmodule

// File: rtl/partition_select.sv
// One partition pass of a quickselect median: split pixels around a pivot, report
// the partition holding rank k, then drain it. Define PARTITION_MINMAX_EN for min/max.
module partition_select
  import median_pkg::*;
#(
  parameter int PX_W      = 8,
  parameter int BUFF_SIZE = 32,
  parameter int SIZE_W    = $clog2(BUFF_SIZE) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PX_W-1:0]   in_px,
  input  logic              in_px_empty,
  output logic              in_px_rd,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [PX_W-1:0]   cfg_pivot,
  input  logic [SIZE_W-1:0] cfg_size,
  input  logic [SIZE_W-1:0] cfg_k,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [1:0]        res_sel,
  output logic [SIZE_W-1:0] res_k,
  output logic [SIZE_W-1:0] res_size,
  output logic [PX_W-1:0]   res_min,
  output logic [PX_W-1:0]   res_max,
  output logic [PX_W-1:0]   out_px,
  output logic              out_px_valid,
  input  logic              out_px_ready
);

  localparam int IDX_W = (BUFF_SIZE > 1) ? $clog2(BUFF_SIZE) : 1;
  localparam logic [SIZE_W-1:0] ONE = SIZE_W'(1);

  logic fill_en, decide_en, drain_en;
  logic cfg_fire, px_accept, fill_last, res_fire, res_drain, drain_fire, drain_last;

  logic [PX_W-1:0]   cur_pivot;
  logic [SIZE_W-1:0] cur_size, cur_k;
  logic [SIZE_W-1:0] acc_cnt, lower_cnt, equal_cnt, larger_cnt, drain_idx;
  sel_t              sel;

  logic [PX_W-1:0] lower_buf  [BUFF_SIZE];
  logic [PX_W-1:0] larger_buf [BUFF_SIZE];

  partition_fsm u_fsm (
    .clk           (clk),
    .rst           (rst),
    .cfg_valid     (cfg_valid),
    .cfg_size_zero (cfg_size == '0),
    .fill_last     (fill_last),
    .res_ready     (res_ready),
    .res_drain     (res_drain),
    .drain_last    (drain_last),
    .cfg_ready     (cfg_ready),
    .fill_en       (fill_en),
    .decide_en     (decide_en),
    .res_valid     (res_valid),
    .drain_en      (drain_en)
  );

  assign cfg_fire     = cfg_valid & cfg_ready;
  assign in_px_rd     = fill_en & (acc_cnt < cur_size);
  assign px_accept    = in_px_rd & ~in_px_empty;
  assign fill_last    = px_accept & (acc_cnt == cur_size - ONE);
  assign res_fire     = res_valid & res_ready;
  assign res_drain    = sel_drains(sel) & (res_size != '0);
  assign out_px_valid = drain_en;
  assign drain_fire   = drain_en & out_px_ready;
  assign drain_last   = drain_fire & (drain_idx == res_size - ONE);
  assign res_sel      = sel;

  // Rank resolution; one bit of headroom so lower+equal and k-lower-equal cannot wrap.
  logic [SIZE_W:0]   k_ext, lower_ext, lower_equal, rem;
  sel_t              dec_sel;
  logic [SIZE_W-1:0] dec_k, dec_size;

  always_comb begin
    // NOTE: every output gets a default before any branch, so no latch can be inferred.
    k_ext       = {1'b0, cur_k};
    lower_ext   = {1'b0, lower_cnt};
    lower_equal = lower_ext + {1'b0, equal_cnt};
    rem         = k_ext - lower_equal;
    dec_sel     = SEL_EMPTY;
    dec_k       = '0;
    dec_size    = '0;
    if (cur_size == '0) begin
      dec_sel = SEL_EMPTY;
    end else if (k_ext < lower_ext) begin
      dec_sel  = SEL_LOWER;
      dec_k    = cur_k;
      dec_size = lower_cnt;
    end else if (k_ext < lower_equal) begin
      dec_sel  = SEL_EQUAL;
      dec_size = equal_cnt;
    end else begin
      dec_sel  = SEL_LARGER;
      dec_size = larger_cnt;
      // Only reachable with k >= size: clamp the rank into the larger partition.
      if (rem >= {1'b0, larger_cnt}) dec_k = (larger_cnt == '0) ? '0 : larger_cnt - ONE;
      else                           dec_k = rem[SIZE_W-1:0];
    end
  end

  // Buffer read port: entry 0 when the drain starts, otherwise the next entry.
  logic [IDX_W-1:0] rd_idx;
  logic [PX_W-1:0]  rd_px;

  always_comb begin
    rd_idx = res_fire ? '0 : IDX_W'(drain_idx + ONE);
    rd_px  = (sel == SEL_LOWER) ? lower_buf[rd_idx] : larger_buf[rd_idx];
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    if (rst) begin
      cur_pivot  <= '0;
      cur_size   <= '0;
      cur_k      <= '0;
      acc_cnt    <= '0;
      lower_cnt  <= '0;
      equal_cnt  <= '0;
      larger_cnt <= '0;
      drain_idx  <= '0;
      sel        <= SEL_LOWER;
      res_k      <= '0;
      res_size   <= '0;
      out_px     <= '0;
    end else begin
      if (cfg_fire) begin
        cur_pivot  <= cfg_pivot;
        cur_size   <= cfg_size;
        cur_k      <= cfg_k;
        acc_cnt    <= '0;
        lower_cnt  <= '0;
        equal_cnt  <= '0;
        larger_cnt <= '0;
      end
      if (px_accept) begin
        acc_cnt <= acc_cnt + ONE;
        if (in_px < cur_pivot)      lower_cnt  <= lower_cnt + ONE;
        else if (in_px > cur_pivot) larger_cnt <= larger_cnt + ONE;
        else                        equal_cnt  <= equal_cnt + ONE;
      end
      if (decide_en) begin
        sel      <= dec_sel;
        res_k    <= dec_k;
        res_size <= dec_size;
      end
      if (res_fire && res_drain) begin
        drain_idx <= '0;
        out_px    <= rd_px;
      end
      if (drain_fire && !drain_last) begin
        drain_idx <= drain_idx + ONE;
        out_px    <= rd_px;
      end
    end
  end

  // NOTE: the buffers have no reset; the partition counters decide which entries are live.
  always_ff @(posedge clk) begin
    if (px_accept) begin
      if (in_px < cur_pivot)      lower_buf[lower_cnt[IDX_W-1:0]]   <= in_px;
      else if (in_px > cur_pivot) larger_buf[larger_cnt[IDX_W-1:0]] <= in_px;
    end
  end

`ifdef PARTITION_MINMAX_EN
  logic [PX_W-1:0] lower_min, lower_max, larger_min, larger_max;

  always_ff @(posedge clk) begin
    if (rst) begin
      lower_min  <= '1;
      lower_max  <= '0;
      larger_min <= '1;
      larger_max <= '0;
      res_min    <= '1;
      res_max    <= '0;
    end else begin
      if (cfg_fire) begin
        lower_min  <= '1;
        lower_max  <= '0;
        larger_min <= '1;
        larger_max <= '0;
      end else if (px_accept) begin
        if (in_px < cur_pivot) begin
          if (in_px < lower_min) lower_min <= in_px;
          if (in_px > lower_max) lower_max <= in_px;
        end else if (in_px > cur_pivot) begin
          if (in_px < larger_min) larger_min <= in_px;
          if (in_px > larger_max) larger_max <= in_px;
        end
      end
      if (decide_en) begin
        case (dec_sel)
          SEL_LOWER:  begin res_min <= lower_min;  res_max <= lower_max;  end
          SEL_EQUAL:  begin res_min <= cur_pivot;  res_max <= cur_pivot;  end
          SEL_LARGER: begin res_min <= larger_min; res_max <= larger_max; end
          default:    begin res_min <= '1;         res_max <= '0;         end
        endcase
      end
    end
  end
`else
  assign res_min = '1;
  assign res_max = '0;
`endif

endmodule

// File: tb/tb_partition_select.sv
// Directed, table-driven bench for partition_select with a FIFO model on the
// negative edge; min/max expectations follow PARTITION_MINMAX_EN.
module tb_partition_select;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_px = '0;
  logic       in_px_empty = 1'b1;
  logic       in_px_rd;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [7:0] cfg_pivot = '0;
  logic [5:0] cfg_size = '0;
  logic [5:0] cfg_k = '0;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [1:0] res_sel;
  logic [5:0] res_k;
  logic [5:0] res_size;
  logic [7:0] res_min;
  logic [7:0] res_max;
  logic [7:0] out_px;
  logic       out_px_valid;
  logic       out_px_ready = 1'b0;

  partition_select dut (
    .clk          (clk),
    .rst          (rst),
    .in_px        (in_px),
    .in_px_empty  (in_px_empty),
    .in_px_rd     (in_px_rd),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_pivot    (cfg_pivot),
    .cfg_size     (cfg_size),
    .cfg_k        (cfg_k),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_sel      (res_sel),
    .res_k        (res_k),
    .res_size     (res_size),
    .res_min      (res_min),
    .res_max      (res_max),
    .out_px       (out_px),
    .out_px_valid (out_px_valid),
    .out_px_ready (out_px_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // FIFO and observer model; everything is sampled and driven on the falling edge.
  logic [7:0] fifo_q[$];
  logic [7:0] drained[$];
  bit gap_mode = 1'b0;
  bit gap_phase = 1'b0;
  bit pend = 1'b0;
  int ncyc = 0;
  int acc_total = 0;
  int last_acc_cyc = -1;
  int rd_last_cyc = -1;
  int hs_cyc = -1;

  always @(negedge clk) begin
    ncyc++;
    if (pend && fifo_q.size() != 0) void'(fifo_q.pop_front());
    gap_phase   = ~gap_phase;
    in_px_empty = (fifo_q.size() == 0) || (gap_mode && gap_phase);
    in_px       = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    pend        = in_px_rd && !in_px_empty;
    if (pend) begin
      acc_total++;
      last_acc_cyc = ncyc;
    end
    if (in_px_rd) rd_last_cyc = ncyc;
    if (cfg_valid && cfg_ready) hs_cyc = ncyc;
    if (out_px_valid && out_px_ready) drained.push_back(out_px);
  end

  typedef struct packed {
    logic [7:0]      pivot;
    logic [5:0]      size;
    logic [5:0]      k;
    logic            gap;
    logic            stall;
    logic [0:7][7:0] px;     // pixel j (j >= 8 repeats entry 7)
    logic [1:0]      sel;
    logic [5:0]      rk;
    logic [5:0]      rsize;
    logic [7:0]      mn;
    logic [7:0]      mx;
    logic [5:0]      ndrain;
    logic [0:7][7:0] dr;     // drained pixel j (j >= 8 repeats entry 7)
  } vec_t;

  localparam int NV = 8;
  vec_t vecs[NV];

  function automatic logic [7:0] exp_min(input vec_t v);
`ifdef PARTITION_MINMAX_EN
    return v.mn;
`else
    return 8'hFF;
`endif
  endfunction

  function automatic logic [7:0] exp_max(input vec_t v);
`ifdef PARTITION_MINMAX_EN
    return v.mx;
`else
    return 8'h00;
`endif
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    int base_acc, base_rd, waited, ref_cyc;
    logic [7:0] first_px;
    drained.delete();
    for (int j = 0; j < int'(v.size); j++) fifo_q.push_back(v.px[j < 8 ? j : 7]);
    fifo_q.push_back(8'hEE);  // sentinel: any over-read shows up in the read count
    gap_mode     = v.gap;
    base_acc     = acc_total;
    base_rd      = rd_last_cyc;
    res_ready    = !v.stall;
    out_px_ready = !v.stall;
    hs_cyc       = -1;
    @(posedge clk); #1;
    cfg_valid = 1'b1;
    cfg_pivot = v.pivot;
    cfg_size  = v.size;
    cfg_k     = v.k;
    @(negedge clk); #1;
    check({tag, " cfg handshake"}, 32'(hs_cyc == ncyc), 32'd1);
    @(posedge clk); #1;
    cfg_valid = 1'b0;

    waited = 0;
    do begin
      @(negedge clk); #1;
      waited++;
    end while (!res_valid && waited < 200);
    check({tag, " res_valid arrives"}, 32'(res_valid), 32'd1);
    ref_cyc = (v.size == 0) ? hs_cyc : last_acc_cyc;
    check({tag, " result latency"}, 32'(ncyc - ref_cyc), 32'd2);
    check({tag, " pixels read"}, 32'(acc_total - base_acc), 32'(v.size));
    check({tag, " last in_px_rd cycle"}, 32'(rd_last_cyc), 32'((v.size == 0) ? base_rd : last_acc_cyc));
    check({tag, " res_sel"}, 32'(res_sel), 32'(v.sel));
    check({tag, " res_k"}, 32'(res_k), 32'(v.rk));
    check({tag, " res_size"}, 32'(res_size), 32'(v.rsize));
    check({tag, " res_min"}, 32'(res_min), 32'(exp_min(v)));
    check({tag, " res_max"}, 32'(res_max), 32'(exp_max(v)));

    if (v.stall) begin
      for (int c = 0; c < 5; c++) begin
        @(negedge clk); #1;
        check({tag, " result held"}, {res_valid, res_sel, res_k, res_size, res_min, res_max},
              {1'b1, v.sel, v.rk, v.rsize, exp_min(v), exp_max(v)});
      end
      @(posedge clk); #1;
      res_ready = 1'b1;
      if (v.ndrain != 0) begin
        waited = 0;
        do begin
          @(negedge clk); #1;
          waited++;
        end while (!out_px_valid && waited < 20);
        check({tag, " drain starts"}, 32'(out_px_valid), 32'd1);
        first_px = v.dr[0];
        for (int c = 0; c < 5; c++) begin
          @(negedge clk); #1;
          check({tag, " out_px held"}, {out_px_valid, out_px, 8'(drained.size())}, {1'b1, first_px, 8'd0});
        end
        @(posedge clk); #1;
        out_px_ready = 1'b1;
      end
    end

    waited = 0;
    while (drained.size() < int'(v.ndrain) && waited < 200) begin
      @(negedge clk); #1;
      waited++;
    end
    repeat (3) begin
      @(negedge clk); #1;
    end
    check({tag, " drain count"}, 32'(drained.size()), 32'(v.ndrain));
    for (int j = 0; j < drained.size() && j < int'(v.ndrain); j++)
      check({tag, $sformatf(" drain[%0d]", j)}, 32'(drained[j]), 32'(v.dr[j < 8 ? j : 7]));
    check({tag, " back to idle"}, {cfg_ready, res_valid, out_px_valid}, 3'b100);
    @(posedge clk); #1;
    fifo_q.delete();
    res_ready    = 1'b0;
    out_px_ready = 1'b0;
    gap_mode     = 1'b0;
  endtask

  initial begin
    vecs[0] = '{pivot:8'd100, size:6'd5, k:6'd2, gap:1'b0, stall:1'b0,
                px:{8'd50, 8'd150, 8'd100, 8'd20, 8'd200, 24'd0},
                sel:2'b01, rk:6'd0, rsize:6'd1, mn:8'd100, mx:8'd100, ndrain:6'd0, dr:64'd0};
    vecs[1] = '{pivot:8'd10, size:6'd4, k:6'd3, gap:1'b0, stall:1'b0,
                px:{8'd30, 8'd5, 8'd40, 8'd20, 32'd0},
                sel:2'b10, rk:6'd2, rsize:6'd3, mn:8'd20, mx:8'd40, ndrain:6'd3,
                dr:{8'd30, 8'd40, 8'd20, 40'd0}};
    vecs[2] = '{pivot:8'd128, size:6'd32, k:6'd5, gap:1'b1, stall:1'b0,
                px:{8{8'd7}},
                sel:2'b00, rk:6'd5, rsize:6'd32, mn:8'd7, mx:8'd7, ndrain:6'd32, dr:{8{8'd7}}};
    vecs[3] = '{pivot:8'd33, size:6'd0, k:6'd0, gap:1'b0, stall:1'b0, px:64'd0,
                sel:2'b11, rk:6'd0, rsize:6'd0, mn:8'hFF, mx:8'h00, ndrain:6'd0, dr:64'd0};
    vecs[4] = '{pivot:8'd50, size:6'd3, k:6'd7, gap:1'b0, stall:1'b0,
                px:{8'd10, 8'd60, 8'd70, 40'd0},
                sel:2'b10, rk:6'd1, rsize:6'd2, mn:8'd60, mx:8'd70, ndrain:6'd2,
                dr:{8'd60, 8'd70, 48'd0}};
    vecs[5] = '{pivot:8'd50, size:6'd2, k:6'd4, gap:1'b0, stall:1'b0,
                px:{8'd10, 8'd50, 48'd0},
                sel:2'b10, rk:6'd0, rsize:6'd0, mn:8'hFF, mx:8'h00, ndrain:6'd0, dr:64'd0};
    vecs[6] = '{pivot:8'd100, size:6'd6, k:6'd1, gap:1'b0, stall:1'b0,
                px:{8'd90, 8'd100, 8'd30, 8'd200, 8'd100, 8'd60, 16'd0},
                sel:2'b00, rk:6'd1, rsize:6'd3, mn:8'd30, mx:8'd90, ndrain:6'd3,
                dr:{8'd90, 8'd30, 8'd60, 40'd0}};
    vecs[7] = vecs[1];
    vecs[7].stall = 1'b1;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #1;
    check("reset cfg_ready", 32'(cfg_ready), 32'd1);
    check("reset res_valid", 32'(res_valid), 32'd0);
    check("reset out_px_valid", 32'(out_px_valid), 32'd0);
    check("reset in_px_rd", 32'(in_px_rd), 32'd0);
    check("reset res_sel", 32'(res_sel), 32'd0);
    check("reset res_k", 32'(res_k), 32'd0);
    check("reset res_size", 32'(res_size), 32'd0);
    check("reset out_px", 32'(out_px), 32'd0);
    check("reset res_min", 32'(res_min), 32'hFF);
    check("reset res_max", 32'(res_max), 32'h00);

    for (int i = 0; i < NV; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset after 3 of 8 pixels: the pass is abandoned, then a fresh pass works.
    begin
      int base_acc, waited;
      for (int j = 0; j < 8; j++) fifo_q.push_back(8'(10 + 20 * j));
      base_acc = acc_total;
      @(posedge clk); #1;
      cfg_valid = 1'b1;
      cfg_pivot = 8'd100;
      cfg_size  = 6'd8;
      cfg_k     = 6'd0;
      @(posedge clk); #1;
      cfg_valid = 1'b0;
      waited = 0;
      do begin
        @(negedge clk); #1;
        waited++;
      end while (acc_total - base_acc < 3 && waited < 50);
      check("midfill reads before reset", 32'(acc_total - base_acc), 32'd3);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk); #1;
      check("midfill cfg_ready after reset", 32'(cfg_ready), 32'd1);
      check("midfill in_px_rd after reset", 32'(in_px_rd), 32'd0);
      repeat (3) begin
        @(negedge clk); #1;
      end
      check("midfill no reads after reset", 32'(acc_total - base_acc), 32'd3);
      check("midfill no result after reset", 32'(res_valid), 32'd0);
      @(posedge clk); #1;
      fifo_q.delete();
    end
    run_vec(vecs[0], "after reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
